// File: rtl/flexsoc_host_pkg.sv
// Shared definitions for the byte-stream bus-forwarding protocol.
// Used by the host responder and by the host slave/master ends of the link.
// Contents: header bit positions, size codes, status bytes, the responder
// state enum, packet length constants and a byte-lane enable helper.
package flexsoc_host_pkg;

    // Request header layout
    localparam int HDR_WRITE_BIT = 7;
    localparam int HDR_RSVD_MSB  = 6;
    localparam int HDR_RSVD_LSB  = 2;
    localparam int HDR_SIZE_MSB  = 1;
    localparam int HDR_SIZE_LSB  = 0;

    // Transfer size codes (AHB HSIZE subset)
    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;
    localparam logic [1:0] SIZE_BAD  = 2'd3;

    // Response status bytes
    localparam logic [7:0] STATUS_OK  = 8'h00;
    localparam logic [7:0] STATUS_ERR = 8'h01;

    // Packet lengths in bytes
    localparam int REQ_HDR_BYTES  = 1;
    localparam int REQ_ADDR_BYTES = 4;
    localparam int REQ_DATA_BYTES = 4;
    localparam int RESP_WRITE_LEN = 1;
    localparam int RESP_READ_LEN  = 5;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_ADDR = 3'd2,
        ST_DATA = 3'd3,
        ST_EXEC = 3'd4,
        ST_RESP = 3'd5
    } state_t;

    // Byte lanes touched by an AHB-style transfer of the given size at the
    // given low address bits. Write data already sits in its natural lanes.
    function automatic logic [3:0] lane_enable(input logic [1:0] size,
                                               input logic [1:0] addr_lo);
        logic [3:0] be;
        be = 4'b0000;
        case (size)
            SIZE_BYTE: be = 4'b0001 << addr_lo;
            SIZE_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
            SIZE_WORD: be = 4'b1111;
            default:   be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/flexsoc_responder_mem.sv
// Single-port synchronous word RAM with per-byte write enables.
// Ports: clk; re (registered read strobe); we/be (byte-enabled write);
// addr (word index); wdata; rdata (registered, holds between reads).
// Contents are not reset.
module flexsoc_responder_mem #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              re,
    input  logic              we,
    input  logic [3:0]        be,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem_array [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem_array[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
        if (re) begin
            rdata <= mem_array[addr];
        end
    end

endmodule

// File: rtl/flexsoc_host_responder.sv
// Host-side responder: pops request packets from a byte FIFO, executes them
// against a local word memory and pushes response packets to a byte FIFO.
// Ports: CLK/RESET (async, active-high); RDEN/RDEMPTY/RDDATA request FIFO
// read side (data one cycle after RDEN); WREN/WRFULL/WRDATA response FIFO
// write side; BUSY (not idle); ERR_CNT (saturating error-response count).
module flexsoc_host_responder
    import flexsoc_host_pkg::*;
#(
    parameter int          DEPTH     = 256,
    parameter logic [31:0] BASE_ADDR = 32'h6000_0000
) (
    input  logic       CLK,
    input  logic       RESET,
    output logic       RDEN,
    input  logic       RDEMPTY,
    input  logic [7:0] RDDATA,
    output logic       WREN,
    input  logic       WRFULL,
    output logic [7:0] WRDATA,
    output logic       BUSY,
    output logic [7:0] ERR_CNT
);

    localparam int AW = $clog2(DEPTH);

    state_t      state_reg, state_next;
    logic        pending_reg;      // a pop was issued last cycle; RDDATA valid now
    logic [1:0]  idx_reg;
    logic [7:0]  hdr_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic        err_reg;
    logic [2:0]  resp_cnt_reg;
    logic [7:0]  err_cnt_reg;

    logic        is_write;
    logic [1:0]  size;
    logic        exec_err;
    logic        resp_last;
    logic        mem_we, mem_re;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;

    assign is_write = hdr_reg[HDR_WRITE_BIT];
    assign size     = hdr_reg[HDR_SIZE_MSB:HDR_SIZE_LSB];

    // BASE_ADDR is 4*DEPTH aligned, so the range check is an upper-bit match.
    always_comb begin
        exec_err = 1'b0;
        if (size == SIZE_BAD)                               exec_err = 1'b1;
        if (|hdr_reg[HDR_RSVD_MSB:HDR_RSVD_LSB])            exec_err = 1'b1;
        if (size == SIZE_HALF && addr_reg[0])               exec_err = 1'b1;
        if (size == SIZE_WORD && addr_reg[1:0] != 2'b00)    exec_err = 1'b1;
        if (addr_reg[31:AW+2] != BASE_ADDR[31:AW+2])        exec_err = 1'b1;
    end

    assign resp_last = is_write ? (resp_cnt_reg == 3'(RESP_WRITE_LEN - 1))
                                : (resp_cnt_reg == 3'(RESP_READ_LEN - 1));

    // State register
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state_reg <= ST_IDLE;
        else       state_reg <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (!RDEMPTY) state_next = ST_HDR;
            ST_HDR:  if (pending_reg) state_next = ST_ADDR;
            ST_ADDR: if (pending_reg && idx_reg == 2'd3)
                         state_next = is_write ? ST_DATA : ST_EXEC;
            ST_DATA: if (pending_reg && idx_reg == 2'd3) state_next = ST_EXEC;
            ST_EXEC: state_next = ST_RESP;
            ST_RESP: if (!WRFULL && resp_last) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        RDEN   = 1'b0;
        WREN   = 1'b0;
        WRDATA = 8'h00;
        mem_we = 1'b0;
        mem_re = 1'b0;
        case (state_reg)
            ST_HDR, ST_ADDR, ST_DATA: RDEN = !pending_reg && !RDEMPTY;
            ST_EXEC: begin
                mem_we = is_write && !exec_err;
                mem_re = !is_write;
            end
            ST_RESP: begin
                WREN = !WRFULL;
                if (resp_cnt_reg == 3'd0) begin
                    WRDATA = err_reg ? STATUS_ERR : STATUS_OK;
                end else if (!err_reg) begin
                    case (resp_cnt_reg)
                        3'd1:    WRDATA = mem_rdata[7:0];
                        3'd2:    WRDATA = mem_rdata[15:8];
                        3'd3:    WRDATA = mem_rdata[23:16];
                        3'd4:    WRDATA = mem_rdata[31:24];
                        default: WRDATA = 8'h00;
                    endcase
                end
            end
            default: ;
        endcase
    end

    assign mem_be  = lane_enable(size, addr_reg[1:0]);
    assign BUSY    = (state_reg != ST_IDLE);
    assign ERR_CNT = err_cnt_reg;

    // Datapath registers
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            pending_reg  <= 1'b0;
            idx_reg      <= 2'd0;
            hdr_reg      <= 8'h00;
            addr_reg     <= 32'h0;
            wdata_reg    <= 32'h0;
            err_reg      <= 1'b0;
            resp_cnt_reg <= 3'd0;
            err_cnt_reg  <= 8'h00;
        end else begin
            // RDEN is only raised with nothing outstanding, so the pending
            // flag simply follows it and clears on the capture cycle.
            pending_reg <= RDEN;
            if (pending_reg) begin
                case (state_reg)
                    ST_HDR:  hdr_reg <= RDDATA;
                    ST_ADDR: begin
                        addr_reg[{idx_reg, 3'b000} +: 8] <= RDDATA;
                        idx_reg <= idx_reg + 2'd1;
                    end
                    ST_DATA: begin
                        wdata_reg[{idx_reg, 3'b000} +: 8] <= RDDATA;
                        idx_reg <= idx_reg + 2'd1;
                    end
                    default: ;
                endcase
            end
            if (state_reg == ST_EXEC) begin
                err_reg      <= exec_err;
                resp_cnt_reg <= 3'd0;
                if (exec_err && err_cnt_reg != 8'hFF) begin
                    err_cnt_reg <= err_cnt_reg + 8'd1;
                end
            end
            if (WREN) begin
                resp_cnt_reg <= resp_cnt_reg + 3'd1;
            end
        end
    end

    flexsoc_responder_mem #(
        .DEPTH (DEPTH),
        .ADDR_W(AW)
    ) u_mem (
        .clk  (CLK),
        .re   (mem_re),
        .we   (mem_we),
        .be   (mem_be),
        .addr (addr_reg[AW+1:2]),
        .wdata(wdata_reg),
        .rdata(mem_rdata)
    );

endmodule

// File: tb/tb_flexsoc_host_responder.sv
// Directed bench for flexsoc_host_responder: byte FIFO models on both sides,
// hand-computed response bytes, one line per transaction.
module tb_flexsoc_host_responder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rden, rdempty, wren, wrfull, busy;
    logic [7:0] rddata, wrdata, err_cnt;

    always #5 clk = ~clk;

    flexsoc_host_responder #(
        .DEPTH    (256),
        .BASE_ADDR(32'h6000_0000)
    ) dut (
        .CLK    (clk),
        .RESET  (rst),
        .RDEN   (rden),
        .RDEMPTY(rdempty),
        .RDDATA (rddata),
        .WREN   (wren),
        .WRFULL (wrfull),
        .WRDATA (wrdata),
        .BUSY   (busy),
        .ERR_CNT(err_cnt)
    );

    // Request FIFO contents (written by the main sequence) and response log
    logic [7:0] req_mem  [0:8191];
    logic [7:0] resp_mem [0:4095];
    int req_wp = 0, req_rp = 0;
    int resp_wp = 0, resp_rp = 0;
    int checks = 0, failures = 0;
    int wren_full_viol = 0, rden_empty_viol = 0;
    logic toggle_en = 1'b0;
    logic rnd_bit = 1'b0;

    assign rdempty = (req_rp == req_wp) || (toggle_en && rnd_bit);

    // FIFO side models: sample handshakes at negedge, update state just
    // after the following posedge (FIFO flags move after the clock edge).
    initial rddata = 8'h00;
    always begin
        logic       pop_ok, push_ok;
        logic [7:0] push_byte;
        @(negedge clk);
        pop_ok    = rden && !rdempty;
        push_ok   = wren && !wrfull;
        push_byte = wrdata;
        if (rden && rdempty) rden_empty_viol++;
        if (wren && wrfull)  wren_full_viol++;
        if (rst) begin
            req_rp = req_wp;
            pop_ok = 1'b0;
        end
        @(posedge clk);
        #1;
        if (pop_ok) begin
            rddata = req_mem[req_rp];
            req_rp++;
        end
        if (push_ok) begin
            resp_mem[resp_wp] = push_byte;
            resp_wp++;
        end
        rnd_bit = 1'($urandom_range(0, 1));
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_b(input logic [7:0] b);
        req_mem[req_wp] = b;
        req_wp++;
    endtask

    task automatic send_read(input logic [7:0] hdr, input logic [31:0] addr);
        push_b(hdr);
        for (int i = 0; i < 4; i++) push_b(addr[8*i +: 8]);
    endtask

    task automatic send_write(input logic [7:0] hdr, input logic [31:0] addr,
                              input logic [31:0] data);
        push_b(hdr);
        for (int i = 0; i < 4; i++) push_b(addr[8*i +: 8]);
        for (int i = 0; i < 4; i++) push_b(data[8*i +: 8]);
    endtask

    // Wait (bounded) for n response bytes and compare them; exp byte 0 in [7:0]
    task automatic expect_resp(input string tag, input int n, input logic [39:0] exp);
        int cyc;
        cyc = 0;
        while (resp_wp < resp_rp + n && cyc < 2000) begin
            tick();
            cyc++;
        end
        check({tag, "_count"}, 32'(resp_wp - resp_rp), 32'(n));
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s[%0d]", tag, i), {24'h0, resp_mem[resp_rp + i]},
                  {24'h0, exp[8*i +: 8]});
        end
        $display("txn %s: %0d response bytes, checks=%0d failures=%0d", tag, n, checks, failures);
        resp_rp = resp_wp;
    endtask

    initial begin
        int cyc;
        wrfull = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst_rden",   {31'h0, rden},   32'h0);
        check("rst_wren",   {31'h0, wren},   32'h0);
        check("rst_wrdata", {24'h0, wrdata}, 32'h0);
        check("rst_busy",   {31'h0, busy},   32'h0);
        check("rst_errcnt", {24'h0, err_cnt}, 32'h0);
        rst = 1'b0;
        tick();

        // Word write then word read at the same address
        send_write(8'h82, 32'h6000_0010, 32'hDEAD_BEEF);
        expect_resp("wr_word", 1, {32'h0, 8'h00});
        check("idle_busy", {31'h0, busy}, 32'h0);
        send_read(8'h02, 32'h6000_0010);
        expect_resp("rd_word", 5, {8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00});

        // Byte write into lane 3 of an existing word
        send_write(8'h82, 32'h6000_0020, 32'h1122_3344);
        expect_resp("wr_base", 1, {32'h0, 8'h00});
        send_write(8'h80, 32'h6000_0023, 32'h5A00_0000);
        expect_resp("wr_byte", 1, {32'h0, 8'h00});
        send_read(8'h02, 32'h6000_0020);
        expect_resp("rd_merge", 5, {8'h5A, 8'h22, 8'h33, 8'h44, 8'h00});

        // Valid half read returns the whole addressed word
        send_read(8'h01, 32'h6000_0012);
        expect_resp("rd_half", 5, {8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00});

        // Misaligned half read -> error
        send_read(8'h01, 32'h6000_0001);
        expect_resp("rd_misal", 5, {32'h0, 8'h01});
        check("errcnt_1", {24'h0, err_cnt}, 32'd1);

        // Misaligned half write must leave memory untouched
        send_write(8'h81, 32'h6000_0011, 32'hFFFF_FFFF);
        expect_resp("wr_misal", 1, {32'h0, 8'h01});
        send_read(8'h02, 32'h6000_0010);
        expect_resp("rd_unchg", 5, {8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00});

        // Out-of-range write below base; framing must survive
        send_write(8'h82, 32'h5FFF_FFFC, 32'h0BAD_0BAD);
        expect_resp("wr_range", 1, {32'h0, 8'h01});
        send_read(8'h02, 32'h6000_0020);
        expect_resp("rd_framed", 5, {8'h5A, 8'h22, 8'h33, 8'h44, 8'h00});

        // One past the top, reserved header bits, size code 3
        send_read(8'h02, 32'h6000_0400);
        expect_resp("rd_top", 5, {32'h0, 8'h01});
        send_read(8'h06, 32'h6000_0010);
        expect_resp("rd_rsvd", 5, {32'h0, 8'h01});
        send_read(8'h03, 32'h6000_0010);
        expect_resp("rd_size3", 5, {32'h0, 8'h01});
        check("errcnt_6", {24'h0, err_cnt}, 32'd6);
        // Last word in range is accepted
        send_write(8'h82, 32'h6000_03FC, 32'hCAFE_F00D);
        expect_resp("wr_last", 1, {32'h0, 8'h00});
        send_read(8'h02, 32'h6000_03FC);
        expect_resp("rd_last", 5, {8'hCA, 8'hFE, 8'hF0, 8'h0D, 8'h00});

        // Request-side stalls plus a 5-cycle WRFULL during the read response
        toggle_en = 1'b1;
        send_read(8'h02, 32'h6000_0010);
        cyc = 0;
        while (resp_wp == resp_rp && cyc < 2000) begin
            tick();
            cyc++;
        end
        check("stall_first", {31'h0, resp_wp > resp_rp}, 32'h1);
        wrfull = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("full_wren%0d", i), {31'h0, wren}, 32'h0);
            check($sformatf("full_hold%0d", i), {24'h0, wrdata}, 32'hEF);
        end
        wrfull = 1'b0;
        toggle_en = 1'b0;
        expect_resp("rd_stall", 5, {8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00});
        check("wren_while_full", 32'(wren_full_viol), 32'h0);
        check("rden_while_empty", 32'(rden_empty_viol), 32'h0);

        // Reset after three address bytes of a write
        push_b(8'h82);
        push_b(8'h10);
        push_b(8'h00);
        push_b(8'h00);
        cyc = 0;
        while (req_rp != req_wp && cyc < 200) begin
            tick();
            cyc++;
        end
        repeat (4) tick();
        check("partial_busy", {31'h0, busy}, 32'h1);
        rst = 1'b1;
        tick();
        check("mid_rden",   {31'h0, rden},   32'h0);
        check("mid_wren",   {31'h0, wren},   32'h0);
        check("mid_wrdata", {24'h0, wrdata}, 32'h0);
        check("mid_busy",   {31'h0, busy},   32'h0);
        check("mid_errcnt", {24'h0, err_cnt}, 32'h0);
        tick();
        rst = 1'b0;
        repeat (10) tick();
        check("mid_no_resp", 32'(resp_wp - resp_rp), 32'h0);
        send_read(8'h02, 32'h6000_0010);
        expect_resp("rd_after_rst", 5, {8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00});

        // Error counter saturation: 255 errors reach FF, the 256th stays
        for (int i = 0; i < 255; i++) begin
            send_read(8'h03, 32'h6000_0000);
            expect_resp($sformatf("err%0d", i), 5, {32'h0, 8'h01});
            if (i == 127) check("errcnt_128", {24'h0, err_cnt}, 32'd128);
        end
        check("errcnt_255", {24'h0, err_cnt}, 32'hFF);
        send_write(8'h83, 32'h6000_0000, 32'h1234_5678);
        expect_resp("err255", 1, {32'h0, 8'h01});
        check("errcnt_sat", {24'h0, err_cnt}, 32'hFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
